// File: rtl/mole_sched_if.sv
// Bundles the game-facing signals of the mole scheduler: random value in,
// debounced presses in, hole/score/flash/status out.
interface mole_sched_if;
   logic        tick;
   logic        start;
   logic [4:0]  rand_val;
   logic [15:0] hit_btn;
   logic [15:0] mole;
   logic [7:0]  score;
   logic [7:0]  round;
   logic        hit_flash;
   logic        miss_flash;
   logic        busy;
   logic        done;

   modport master (
      output tick, start, rand_val, hit_btn,
      input  mole, score, round, hit_flash, miss_flash, busy, done
   );

   modport slave (
      input  tick, start, rand_val, hit_btn,
      output mole, score, round, hit_flash, miss_flash, busy, done
   );
endinterface

// File: rtl/mole_sched.sv
// Whack-a-mole round scheduler: picks a hole and a gap length from the random
// value, times the mole's up-window, judges hits, keeps score and round count.
// Optional build macro PENALTY_EN: a wrong-hole press while a mole is up is
// scored as a miss and costs one point.
//
// state  | meaning
// IDLE   | waiting for start after reset
// GAP    | random-length pause before the next mole
// UP     | mole lit, waiting for a press or timeout
// RESULT | hit/miss feedback shown
// DONE   | game over, waiting for start
module mole_sched #(
   parameter int GAP_TICKS    = 8,
   parameter int UP_TICKS     = 20,
   parameter int RESULT_TICKS = 4,
   parameter int ROUNDS       = 20
) (
   input  logic         clk,
   input  logic         rst,
   mole_sched_if.slave  bus
);

   typedef enum logic [2:0] {S_IDLE, S_GAP, S_UP, S_RESULT, S_DONE} state_t;

   state_t      state, state_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic [3:0]  prev_hole, prev_nxt;
   logic        first, first_nxt;
   logic [15:0] mole_q, mole_nxt;
   logic [7:0]  score_q, score_nxt;
   logic [7:0]  round_q, round_nxt;
   logic        hit_q, hit_nxt;
   logic        miss_q, miss_nxt;
   logic        busy_q, busy_nxt;
   logic        done_q, done_nxt;
   logic [15:0] gap_load;
   logic [3:0]  cand, hole;

   assign gap_load = 16'(GAP_TICKS) + {11'd0, bus.rand_val};
   assign cand     = bus.rand_val[3:0];
   // Never light the same hole twice in a row within a game.
   assign hole     = (!first && cand == prev_hole) ? cand + 4'd1 : cand;

   assign bus.mole       = mole_q;
   assign bus.score      = score_q;
   assign bus.round      = round_q;
   assign bus.hit_flash  = hit_q;
   assign bus.miss_flash = miss_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         prev_hole <= '0;
         first     <= 1'b1;
         mole_q    <= '0;
         score_q   <= '0;
         round_q   <= '0;
         hit_q     <= 1'b0;
         miss_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         prev_hole <= prev_nxt;
         first     <= first_nxt;
         mole_q    <= mole_nxt;
         score_q   <= score_nxt;
         round_q   <= round_nxt;
         hit_q     <= hit_nxt;
         miss_q    <= miss_nxt;
         busy_q    <= busy_nxt;
         done_q    <= done_nxt;
      end
   end

   // Next-state and next-output decisions.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      prev_nxt  = prev_hole;
      first_nxt = first;
      mole_nxt  = mole_q;
      score_nxt = score_q;
      round_nxt = round_q;
      hit_nxt   = hit_q;
      miss_nxt  = miss_q;
      case (state)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               score_nxt = '0;
               round_nxt = '0;
               hit_nxt   = 1'b0;
               miss_nxt  = 1'b0;
               first_nxt = 1'b1;
               cnt_nxt   = gap_load;
               state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            if (bus.tick) begin
               if (cnt == 16'd1) begin
                  prev_nxt  = hole;
                  first_nxt = 1'b0;
                  mole_nxt  = 16'd1 << hole;
                  cnt_nxt   = 16'(UP_TICKS);
                  state_nxt = S_UP;
               end else begin
                  cnt_nxt = cnt - 16'd1;
               end
            end
         end
         S_UP: begin
            if (bus.hit_btn[prev_hole]) begin
               score_nxt = (score_q == 8'hff) ? score_q : score_q + 8'd1;
               mole_nxt  = '0;
               hit_nxt   = 1'b1;
               round_nxt = round_q + 8'd1;
               cnt_nxt   = 16'(RESULT_TICKS);
               state_nxt = S_RESULT;
            end
`ifdef PENALTY_EN
            else if (|bus.hit_btn) begin
               score_nxt = (score_q == 8'd0) ? score_q : score_q - 8'd1;
               mole_nxt  = '0;
               miss_nxt  = 1'b1;
               round_nxt = round_q + 8'd1;
               cnt_nxt   = 16'(RESULT_TICKS);
               state_nxt = S_RESULT;
            end
`endif
            else if (bus.tick) begin
               if (cnt == 16'd1) begin
                  mole_nxt  = '0;
                  miss_nxt  = 1'b1;
                  round_nxt = round_q + 8'd1;
                  cnt_nxt   = 16'(RESULT_TICKS);
                  state_nxt = S_RESULT;
               end else begin
                  cnt_nxt = cnt - 16'd1;
               end
            end
         end
         S_RESULT: begin
            if (bus.tick) begin
               if (cnt == 16'd1) begin
                  hit_nxt  = 1'b0;
                  miss_nxt = 1'b0;
                  if (round_q == 8'(ROUNDS)) begin
                     state_nxt = S_DONE;
                  end else begin
                     cnt_nxt   = gap_load;
                     state_nxt = S_GAP;
                  end
               end else begin
                  cnt_nxt = cnt - 16'd1;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      busy_nxt = (state_nxt == S_GAP) || (state_nxt == S_UP) || (state_nxt == S_RESULT);
      done_nxt = (state_nxt == S_DONE);
   end

endmodule

// File: tb/tb_mole_sched.sv
module tb_mole_sched;

   localparam int GAP = 2;
   localparam int UPT = 4;
   localparam int RES = 1;
   localparam int RND = 3;

   logic clk;
   logic rst;
   mole_sched_if bus ();

   mole_sched #(.GAP_TICKS(GAP), .UP_TICKS(UPT), .RESULT_TICKS(RES), .ROUNDS(RND))
      dut (.clk(clk), .rst(rst), .bus(bus));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [35:0] outs();
      return {bus.mole, bus.score, bus.round, bus.hit_flash, bus.miss_flash, bus.busy, bus.done};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic        start;
      logic [15:0] hit;
      logic [35:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic st, input logic [15:0] hit, input logic [15:0] mole,
                               input logic [7:0] sc, input logic [7:0] rd, input logic hf,
                               input logic mf, input logic by, input logic dn);
      vec_t v;
      v.start = st;
      v.hit   = hit;
      v.exp   = {mole, sc, rd, hf, mf, by, dn};
      tbl.push_back(v);
   endfunction

   // ---------------- reference model ----------------
   localparam int P_IDLE = 0, P_GAP = 1, P_UP = 2, P_RES = 3, P_DONE = 4;
   int          m_ph, m_left, m_prev, m_score, m_round;
   bit          m_first, m_hf, m_mf;
   logic [15:0] m_mole;

   function automatic void m_reset();
      m_ph = P_IDLE; m_left = 0; m_prev = 0; m_first = 1;
      m_score = 0; m_round = 0; m_hf = 0; m_mf = 0; m_mole = '0;
   endfunction

   function automatic void m_end_round(input bit hit_ok, input int dscore);
      m_score = m_score + dscore;
      if (m_score > 255) m_score = 255;
      if (m_score < 0) m_score = 0;
      m_round++;
      m_mole = '0;
      m_hf = hit_ok;
      m_mf = !hit_ok;
      m_left = RES;
      m_ph = P_RES;
   endfunction

   function automatic void m_step(input bit tk, input bit st, input int rv, input logic [15:0] hit);
      int c;
      bit pen;
`ifdef PENALTY_EN
      pen = 1;
`else
      pen = 0;
`endif
      if (m_ph == P_IDLE || m_ph == P_DONE) begin
         if (st) begin
            m_score = 0; m_round = 0; m_hf = 0; m_mf = 0; m_first = 1;
            m_left = GAP + rv; m_ph = P_GAP;
         end
      end else if (m_ph == P_GAP) begin
         if (tk) begin
            m_left--;
            if (m_left == 0) begin
               c = rv % 16;
               if (!m_first && c == m_prev) c = (c + 1) % 16;
               m_prev = c; m_first = 0;
               m_mole = 16'(1 << c);
               m_left = UPT; m_ph = P_UP;
            end
         end
      end else if (m_ph == P_UP) begin
         if (hit[m_prev]) m_end_round(1, 1);
         else if (pen && hit != 0) m_end_round(0, -1);
         else if (tk) begin
            m_left--;
            if (m_left == 0) m_end_round(0, 0);
         end
      end else if (m_ph == P_RES) begin
         if (tk) begin
            m_left--;
            if (m_left == 0) begin
               m_hf = 0; m_mf = 0;
               if (m_round == RND) m_ph = P_DONE;
               else begin
                  m_left = GAP + rv; m_ph = P_GAP;
               end
            end
         end
      end
   endfunction

   function automatic logic [35:0] m_outs();
      bit by;
      by = (m_ph == P_GAP) || (m_ph == P_UP) || (m_ph == P_RES);
      return {m_mole, 8'(m_score), 8'(m_round), m_hf, m_mf, by, (m_ph == P_DONE)};
   endfunction

   initial begin
      rst = 1'b1;
      bus.tick = 1'b1; bus.start = 1'b0; bus.rand_val = 5'd5; bus.hit_btn = '0;
      #1;
      check("reset_outputs", outs(), 36'h0);
      #20;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Game with rand held at 5, tick every cycle.
      add(1, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 0, 0, 0, 1, 0);
      add(0, 0, 16'h0020, 0, 0, 0, 0, 1, 0);
      add(0, 0, 16'h0020, 0, 0, 0, 0, 1, 0);
      add(0, 16'h0020, 0, 1, 1, 1, 0, 1, 0);
      add(0, 0, 0, 1, 1, 0, 0, 1, 0);
      for (int i = 0; i < 6; i++) add(0, 0, 0, 1, 1, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) add(0, 0, 16'h0040, 1, 1, 0, 0, 1, 0);
      add(0, 0, 0, 1, 2, 0, 1, 1, 0);
      add(0, 0, 0, 1, 2, 0, 0, 1, 0);
      for (int i = 0; i < 6; i++) add(0, 0, 0, 1, 2, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) add(0, 0, 16'h0020, 1, 2, 0, 0, 1, 0);
      add(0, 0, 0, 1, 3, 0, 1, 1, 0);
      add(0, 0, 0, 1, 3, 0, 0, 0, 1);
      add(1, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) add(0, 0, 16'h0020, 0, 0, 0, 0, 1, 0);
      add(0, 16'h0020, 0, 1, 1, 1, 0, 1, 0);

      foreach (tbl[i]) begin
         bus.start = tbl[i].start;
         bus.hit_btn = tbl[i].hit;
         cyc();
         check($sformatf("table_%0d", i), outs(), tbl[i].exp);
      end
      bus.start = 0; bus.hit_btn = '0;

      // Asynchronous reset in the middle of an up-window.
      rst = 1'b1; #2; rst = 1'b0;
      cyc();
      bus.start = 1;
      cyc();
      bus.start = 0;
      for (int i = 0; i < 7; i++) cyc();
      check("pre_reset_mole", 64'(bus.mole), 64'h0020);
      #2 rst = 1'b1;
      #1;
      check("async_reset_mole_busy", {bus.mole, bus.busy}, 17'h0);
      cyc();
      rst = 1'b0;
      cyc();
      check("after_reset_idle", outs(), 36'h0);

      // Wrong-hole press while a mole is up.
      bus.start = 1;
      cyc();
      bus.start = 0;
      for (int i = 0; i < 7; i++) cyc();
      bus.hit_btn = 16'h0020;
      cyc();
      bus.hit_btn = '0;
      check("pen_setup_score", 64'(bus.score), 64'd1);
      for (int i = 0; i < 8; i++) cyc();
      check("pen_mole_lit", 64'(bus.mole), 64'h0040);
      bus.hit_btn = 16'h0001;
      cyc();
      bus.hit_btn = '0;
`ifdef PENALTY_EN
      check("pen_wrong_press", {bus.mole, bus.score, bus.miss_flash}, {16'h0, 8'd0, 1'b1});
      cyc();
      for (int i = 0; i < 7; i++) cyc();
      check("pen_mole_lit2", 64'(bus.mole), 64'h0020);
      bus.hit_btn = 16'h8000;
      cyc();
      bus.hit_btn = '0;
      check("pen_saturate_zero", {bus.score, bus.miss_flash, bus.done}, {8'd0, 1'b1, 1'b0});
`else
      check("nopen_wrong_press", {bus.mole, bus.score, bus.miss_flash}, {16'h0040, 8'd1, 1'b0});
`endif

      // Randomized games against the reference model.
      rst = 1'b1;
      m_reset();
      #2;
      rst = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         bus.tick     = ($urandom_range(0, 1) == 1);
         bus.rand_val = 5'($urandom_range(1, 30));
         bus.start    = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 7))
            0, 1:    bus.hit_btn = m_mole;
            2:       bus.hit_btn = 16'(1 << $urandom_range(0, 15));
            3:       bus.hit_btn = 16'($urandom);
            default: bus.hit_btn = '0;
         endcase
         @(posedge clk);
         m_step(bus.tick, bus.start, int'(bus.rand_val), bus.hit_btn);
         #1;
         check($sformatf("random_%0d", i), outs(), m_outs());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
